// File: rtl/replication_unpacker.sv
// Receive-side unpacker for {a, 4x b0, c1} words: majority-decodes b0 into a single
// output register on a valid/ready stream and keeps saturating error statistics.
module replication_unpacker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_a,
    output logic             out_b0,
    output logic             out_c1,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic             err_sticky
);

    localparam int unsigned     W_W     = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept;
    logic [W_W-1:0]   weight;
    logic             dec_b0, dec_corr, dec_uncorr;

    logic             out_a_q, out_a_d;
    logic             out_b0_q, out_b0_d;
    logic             out_c1_q, out_c1_d;
    logic             out_corr_q, out_corr_d;
    logic             out_uncorr_q, out_uncorr_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    // Single-stage register: ready whenever the slot is empty or draining this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // 4x repetition decode of the b0 copies
    always_comb begin
        weight = W_W'(in_data[4]) + W_W'(in_data[3]) + W_W'(in_data[2]) + W_W'(in_data[1]);
        dec_b0     = 1'b0;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        case (weight)
            3'd4:    dec_b0 = 1'b1;
            3'd3: begin
                dec_b0   = 1'b1;
                dec_corr = 1'b1;
            end
            3'd2:    dec_uncorr = 1'b1;
            3'd1:    dec_corr = 1'b1;
            default: dec_b0 = 1'b0;
        endcase
    end

    always_comb begin
        out_a_d      = out_a_q;
        out_b0_d     = out_b0_q;
        out_c1_d     = out_c1_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_valid_d  = out_valid_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        err_sticky_d = err_sticky_q;

        if (accept) begin
            out_a_d      = in_data[5];
            out_b0_d     = dec_b0;
            out_c1_d     = in_data[0];
            out_corr_d   = dec_corr;
            out_uncorr_d = dec_uncorr;
            out_valid_d  = 1'b1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end

        // Statistics track accepted words; clear wins over a same-cycle update.
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            err_sticky_d = 1'b0;
        end else if (accept) begin
            if (dec_corr && corr_cnt_q != CNT_MAX)
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            if (dec_uncorr && uncorr_cnt_q != CNT_MAX)
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            if (dec_uncorr)
                err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a_q      <= 1'b0;
            out_b0_q     <= 1'b0;
            out_c1_q     <= 1'b0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_valid_q  <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_a_q      <= out_a_d;
            out_b0_q     <= out_b0_d;
            out_c1_q     <= out_c1_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_valid_q  <= out_valid_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_a      = out_a_q;
    assign out_b0     = out_b0_q;
    assign out_c1     = out_c1_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign out_valid  = out_valid_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_replication_unpacker.sv
// Directed bench for replication_unpacker: decode table, statistics, backpressure,
// counter saturation (narrow instance) and asynchronous reset.
module tb_replication_unpacker;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_a, out_b0, out_c1, out_corr, out_uncorr, out_valid;
    logic       out_ready;
    logic       clr_cnt;
    logic [7:0] corr_cnt, uncorr_cnt;
    logic       err_sticky;

    logic       in_ready2;
    logic       out_a2, out_b02, out_c12, out_corr2, out_uncorr2, out_valid2;
    logic [1:0] corr_cnt2, uncorr_cnt2;
    logic       err_sticky2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    replication_unpacker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b0(out_b0), .out_c1(out_c1), .out_corr(out_corr),
        .out_uncorr(out_uncorr), .out_valid(out_valid), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_sticky(err_sticky)
    );

    replication_unpacker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .out_a(out_a2), .out_b0(out_b02), .out_c1(out_c12), .out_corr(out_corr2),
        .out_uncorr(out_uncorr2), .out_valid(out_valid2), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2), .err_sticky(err_sticky2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the output word {valid,a,b0,c1,corr,uncorr}
    task automatic check_out(input string tag, input logic [5:0] exp);
        check(tag, 32'({out_valid, out_a, out_b0, out_c1, out_corr, out_uncorr}), 32'(exp));
    endtask

    task automatic check_stats(input string tag, input int c, input int u, input logic s);
        check({tag, ".corr_cnt"}, 32'(corr_cnt), 32'(c));
        check({tag, ".uncorr_cnt"}, 32'(uncorr_cnt), 32'(u));
        check({tag, ".sticky"}, 32'(err_sticky), 32'(s));
    endtask

    // One accepted word, then in_valid drops; sampled 1 ns after the edge.
    task automatic send(input logic [5:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        #1;
        check_out("reset.out", 6'b0_000_00);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check_stats("reset", 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // all copies agree
        send(6'b1_1111_0);
        check_out("w4", 6'b1_110_00);
        check_stats("w4", 0, 0, 1'b0);

        // single-bit disagreements
        send(6'b0_1101_1);
        check_out("w3", 6'b1_011_10);
        send(6'b1_0100_0);
        check_out("w1", 6'b1_100_10);
        check_stats("single", 2, 0, 1'b0);

        // 2-2 tie
        send(6'b0_0110_1);
        check_out("tie", 6'b1_001_01);
        check_stats("tie", 2, 1, 1'b1);

        // clear has priority over a same-cycle tie, data path unaffected
        clr_cnt = 1'b1;
        send(6'b1_1010_0);
        clr_cnt = 1'b0;
        check_out("clr.out", 6'b1_100_01);
        check_stats("clr", 0, 0, 1'b0);

        // backpressure: stored tie word must hold, new word waits
        out_ready = 1'b0;
        in_data   = 6'b1_1111_0;
        in_valid  = 1'b1;
        #1;
        check("bp.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_out("bp.hold", 6'b1_100_01);
            check("bp.in_ready_hold", 32'(in_ready), 32'd0);
            check_stats("bp", 0, 0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_out("bp.replace", 6'b1_110_00);
        @(posedge clk); #1;
        check_out("bp.drained", 6'b0_110_00);
        check("bp.in_ready_empty", 32'(in_ready), 32'd1);

        // back-to-back single-error words: 8-bit counts 5, 2-bit saturates at 3
        in_data  = 6'b0_1101_1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stream.valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        check("sat.corr_cnt8", 32'(corr_cnt), 32'd5);
        check("sat.corr_cnt2", 32'(corr_cnt2), 32'd3);
        send(6'b1_0111_1);
        check("sat.corr_cnt2_hold", 32'(corr_cnt2), 32'd3);
        check("sat.corr_cnt8_next", 32'(corr_cnt), 32'd6);

        // asynchronous reset while a word is stalled
        out_ready = 1'b0;
        send(6'b1_1101_1);
        check_out("prerst", 6'b1_111_10);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst.out", 6'b0_000_00);
        check("async_rst.in_ready", 32'(in_ready), 32'd1);
        check_stats("async_rst", 0, 0, 1'b0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        send(6'b0_0001_0);
        check_out("post_rst", 6'b1_000_10);
        check_stats("post_rst", 1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
